hilo_div_unit: RTL and testbench
================================

HILO_DIV_UNIT -- requirements
Module: hilo_div_unit

Interface
REQ-001 Parameter: DIV_CYCLES, default 32, number of quotient-bit iterations per division.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: op  input  3  command: 0 NOP, 1 LOADP (capture ALU product), 2 DIV (signed), 3 DIVU, 4 MTHI, 5 MTLO, 6-7 treated as NOP.
REQ-005 Port: a  input  32  dividend for DIV/DIVU; source operand for MTHI/MTLO.
REQ-006 Port: b  input  32  divisor for DIV/DIVU.
REQ-007 Port: alu_r  input  32  low 32 bits of the ALU multu result.
REQ-008 Port: alu_r2  input  32  high 32 bits of the ALU multu result.
REQ-009 Port: hi  output  32  HI register.
REQ-010 Port: lo  output  32  LO register.
REQ-011 Port: busy  output  1  high while a division is in progress.
REQ-012 Port: done  output  1  one-cycle pulse when a division result is written.
REQ-013 Port: div_zero  output  1  sticky flag, set by a division with b==0, cleared by the next accepted DIV/DIVU.

Function
REQ-014 States SHALL be IDLE, ITER and FIX; op SHALL be sampled only in IDLE and SHALL be ignored in ITER and FIX.
REQ-015 LOADP in IDLE SHALL write hi=alu_r2 and lo=alu_r at that edge; busy and done SHALL stay 0.
REQ-016 MTHI in IDLE SHALL write hi=a; MTLO in IDLE SHALL write lo=a; the other register SHALL be unchanged.
REQ-017 DIV/DIVU with b!=0 in IDLE SHALL latch |a| and |b| (DIV) or a and b (DIVU) plus the sign flags, clear div_zero, and enter ITER with iteration count 0.
REQ-018 ITER SHALL perform one restoring-division step per edge (shift the remainder/quotient pair left by 1, trial-subtract the divisor, set the quotient bit when the result is non-negative) and SHALL exit to FIX after DIV_CYCLES steps.
REQ-019 FIX SHALL write lo=quotient and hi=remainder, negating the quotient if the operand signs differ and negating the remainder if the dividend is negative (DIV only), then return to IDLE with done=1 for exactly that cycle.
REQ-020 Latency: with the command sampled at edge 0, hi/lo SHALL be valid and done high after edge DIV_CYCLES+1 (edge 33 by default); busy SHALL be high from edge 0 through edge DIV_CYCLES+1.
REQ-021 Signed quotients SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 with no flag raised.
REQ-023 DIV/DIVU with b==0 SHALL skip ITER and, at the sampling edge, write hi=a, lo=0xFFFFFFFF, set div_zero, and pulse done in the following cycle; busy SHALL stay 0.
REQ-024 hi and lo SHALL hold their values in every cycle not covered by REQ-015, REQ-016, REQ-019 and REQ-023, including the whole of ITER.

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0 and all internal datapath registers to 0, including when a division is in progress; no result of an aborted division SHALL be written.

Structure
REQ-026 A shared package SHALL hold the op code constants, the state encoding and the DIV_CYCLES default.
REQ-027 One combinational sub-module, hilo_div_step, SHALL implement a single restoring step (inputs: remainder, quotient, divisor; outputs: next remainder, next quotient).

Verification
REQ-028 DIVU a=100, b=7 -> at edge 33: lo=14, hi=2, done=1 for one cycle, busy=0 afterwards.
REQ-029 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-030 DIVU a=5, b=0 -> hi=5, lo=0xFFFFFFFF, div_zero=1, no busy; a following DIVU 9/3 -> div_zero=0, lo=3, hi=0.
REQ-031 LOADP with alu_r=0x12345678, alu_r2=0x9ABCDEF0 -> next cycle lo=0x12345678, hi=0x9ABCDEF0; then MTHI a=1 -> hi=1, lo unchanged.
REQ-032 MTLO and LOADP issued during ITER -> hi/lo unchanged, division result unaffected.
REQ-033 reset_n pulsed low at iteration 10 of a DIVU -> hi=lo=0, busy=0, done never asserted; a following LOADP works normally.

Source files
------------

// File: rtl/hilo_div_pkg.sv
// Shared definitions for the HI/LO multiply-capture and restoring divide unit.
package hilo_div_pkg;

    localparam int DIV_CYCLES_DEF = 32;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOADP = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // 0x80000000 maps to itself, which is exactly the unsigned magnitude we need.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_div_step.sv
// One restoring-division step on a remainder/quotient pair.
module hilo_div_step (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] dvsr,
    output logic [31:0] rem_nxt,
    output logic [31:0] quo_nxt
);

    logic [32:0] shifted;
    logic [32:0] diff;

    always_comb begin
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, dvsr};
        if (!diff[32]) begin
            rem_nxt = diff[31:0];
            quo_nxt = {quo[30:0], 1'b1};
        end else begin
            rem_nxt = shifted[31:0];
            quo_nxt = {quo[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_div_unit.sv
// HI/LO register pair with product capture, moves and a multi-cycle divider.
//   state   | meaning
//   IDLE    | accepting op; LOADP/MTHI/MTLO and divide-by-zero complete here
//   ITER    | one restoring step per clock, op ignored
//   FIX     | apply signs, write HI/LO, pulse done
module hilo_div_unit
    import hilo_div_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] alu_r,
    input  logic [31:0] alu_r2,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    localparam int CW = $clog2(DIV_CYCLES + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(DIV_CYCLES - 1);

    state_t        state;
    logic [31:0]   rem;
    logic [31:0]   quo;
    logic [31:0]   dvsr;
    logic          neg_q;
    logic          neg_r;
    logic [CW-1:0] cnt;
    logic [31:0]   rem_nxt;
    logic [31:0]   quo_nxt;

    hilo_div_step u_step (
        .rem     (rem),
        .quo     (quo),
        .dvsr    (dvsr),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    case (op)
                        OP_LOADP: begin
                            hi <= alu_r2;
                            lo <= alu_r;
                        end
                        OP_MTHI: hi <= a;
                        OP_MTLO: lo <= a;
                        OP_DIV, OP_DIVU: begin
                            if (b == 32'd0) begin
                                hi       <= a;
                                lo       <= '1;
                                div_zero <= 1'b1;
                                done     <= 1'b1;
                            end else begin
                                div_zero <= 1'b0;
                                busy     <= 1'b1;
                                cnt      <= '0;
                                rem      <= '0;
                                state    <= ST_ITER;
                                if (op == OP_DIV) begin
                                    quo   <= abs32(a);
                                    dvsr  <= abs32(b);
                                    neg_q <= a[31] ^ b[31];
                                    neg_r <= a[31];
                                end else begin
                                    quo   <= a;
                                    dvsr  <= b;
                                    neg_q <= 1'b0;
                                    neg_r <= 1'b0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                ST_ITER: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) state <= ST_FIX;
                end
                ST_FIX: begin
                    lo    <= neg_q ? (~quo + 32'd1) : quo;
                    hi    <= neg_r ? (~rem + 32'd1) : rem;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit with hand-computed expected values.
module tb_hilo_div_unit;
    import hilo_div_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  op;
    logic [31:0] a, b, alu_r, alu_r2;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    int n_tests = 0;
    int n_fail  = 0;

    hilo_div_unit #(.DIV_CYCLES(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .op       (op),
        .a        (a),
        .b        (b),
        .alu_r    (alu_r),
        .alu_r2   (alu_r2),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a command for exactly one rising edge; returns 1ns after that edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        op = o;
        a  = va;
        b  = vb;
        @(posedge clk);
        #1;
        op = OP_NOP;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
    endtask

    task automatic run_div(input string tag, input logic [2:0] o, input logic [31:0] va,
                           input logic [31:0] vb, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi);
        int n;
        issue(o, va, vb);
        chk({tag, "_busy0"}, 32'(busy), 32'd1);
        chk({tag, "_dz_clr"}, 32'(div_zero), 32'd0);
        wait_done(n);
        chk({tag, "_lat"}, 32'(n), 32'd33);
        chk({tag, "_lo"}, lo, exp_lo);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int  n;
        logic saw_done;

        reset_n = 1'b0;
        op = OP_NOP; a = '0; b = '0; alu_r = '0; alu_r2 = '0;
        #12;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
        run_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        chk("div_min_m1_dz", 32'(div_zero), 32'd0);

        issue(OP_DIVU, 32'd5, 32'd0);
        chk("dz_hi", hi, 32'd5);
        chk("dz_lo", lo, 32'hFFFF_FFFF);
        chk("dz_flag", 32'(div_zero), 32'd1);
        chk("dz_busy", 32'(busy), 32'd0);
        chk("dz_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        chk("dz_done_pulse", 32'(done), 32'd0);
        chk("dz_sticky", 32'(div_zero), 32'd1);

        run_div("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 32'd0);

        alu_r  = 32'h1234_5678;
        alu_r2 = 32'h9ABC_DEF0;
        issue(OP_LOADP, 32'd0, 32'd0);
        chk("loadp_lo", lo, 32'h1234_5678);
        chk("loadp_hi", hi, 32'h9ABC_DEF0);
        chk("loadp_busy", 32'(busy), 32'd0);
        chk("loadp_done", 32'(done), 32'd0);

        issue(OP_MTHI, 32'd1, 32'd0);
        chk("mthi_hi", hi, 32'd1);
        chk("mthi_lo", lo, 32'h1234_5678);

        issue(OP_MTLO, 32'hCAFE_0001, 32'd0);
        chk("mtlo_lo", lo, 32'hCAFE_0001);
        chk("mtlo_hi", hi, 32'd1);

        issue(3'd6, 32'h5555_5555, 32'd0);
        chk("op6_lo", lo, 32'hCAFE_0001);
        chk("op6_hi", hi, 32'd1);

        // Commands arriving mid-division must be ignored.
        issue(OP_DIVU, 32'd1000, 32'd10);
        repeat (4) @(posedge clk);
        @(negedge clk);
        op = OP_MTLO; a = 32'hDEAD_BEEF;
        @(negedge clk);
        op = OP_LOADP; alu_r = 32'h0BAD_0BAD; alu_r2 = 32'h0F0F_0F0F;
        @(negedge clk);
        op = OP_NOP;
        chk("iter_hold_hi", hi, 32'd1);
        chk("iter_hold_lo", lo, 32'hCAFE_0001);
        chk("iter_busy", 32'(busy), 32'd1);
        wait_done(n);
        chk("iter_lat", 32'(n), 32'd27);
        chk("iter_lo", lo, 32'd100);
        chk("iter_hi", hi, 32'd0);

        // Abort a division at iteration 10.
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd3);
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        chk("abort_lo_hold", lo, 32'd0);

        alu_r  = 32'h0000_0011;
        alu_r2 = 32'h0000_0022;
        issue(OP_LOADP, 32'd0, 32'd0);
        chk("post_rst_lo", lo, 32'h0000_0011);
        chk("post_rst_hi", hi, 32'h0000_0022);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
